// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding request/ready data-memory port with byte-lane alignment and load extension.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned H/W accesses; otherwise they are forced to natural alignment.
module load_store_unit #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 Start,
  input  logic                 Is_Store,
  input  logic [2:0]           Funct3,
  input  logic [DATAWIDTH-1:0] Alu_Result,
  input  logic [DATAWIDTH-1:0] Store_Data,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Misaligned,
  output logic [DATAWIDTH-1:0] Load_Data,
  output logic                 Mem_Req,
  output logic                 Mem_We,
  output logic [DATAWIDTH-1:0] Mem_Addr,
  output logic [3:0]           Mem_Be,
  output logic [DATAWIDTH-1:0] Mem_Wdata,
  input  logic                 Mem_Ready,
  input  logic [DATAWIDTH-1:0] Mem_Rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, next_state;

  logic           illegal, mis, reject;
  logic [1:0]     off;
  logic [3:0]     be;
  logic [31:0]    wdata;
  logic [2:0]     funct3_q;
  logic [1:0]     off_q;
  logic           mis_q;
  logic [31:0]    shifted, ext;

  // Request decode from the raw inputs, used only on the accepting edge
  always_comb begin
    illegal = (Funct3[1:0] == 2'b11) || (Funct3[2] && (Is_Store || Funct3[1]));
    off     = Alu_Result[1:0];
    mis     = 1'b0;
    be      = '0;
    wdata   = '0;
    case (Funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{Store_Data[7:0]}};
      end
      2'b01: begin
`ifdef LSU_MISALIGN_TRAP_EN
        mis = off[0];
`else
        off[0] = 1'b0;
`endif
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{Store_Data[15:0]}};
      end
      2'b10: begin
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (off != 2'b00);
`else
        off = 2'b00;
`endif
        be    = 4'b1111;
        wdata = Store_Data;
      end
      default: ;
    endcase
    mis    = mis && !illegal;
    reject = illegal || mis;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = reject ? DONE : REQ;
      REQ:     if (Mem_Ready) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    Busy       = (state != IDLE);
    Done       = (state == DONE);
    Mem_Req    = (state == REQ);
    Misaligned = (state == DONE) && mis_q;
  end

  always_comb begin
    shifted = Mem_Rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'h0, shifted[7:0]};
      3'b101:  ext = {16'h0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  // Port fields are registered at acceptance so they stay stable while REQ waits
  always_ff @(posedge CLK) begin
    if (RESET) begin
      funct3_q  <= '0;
      off_q     <= '0;
      mis_q     <= 1'b0;
      Mem_We    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_Be    <= '0;
      Mem_Wdata <= '0;
      Load_Data <= '0;
    end else begin
      if (state == IDLE && Start) begin
        funct3_q  <= Funct3;
        off_q     <= off;
        mis_q     <= mis;
        Mem_We    <= Is_Store;
        Mem_Addr  <= {Alu_Result[DATAWIDTH-1:2], 2'b00};
        Mem_Be    <= be;
        Mem_Wdata <= wdata;
      end
      if (state == REQ && Mem_Ready && !Mem_We)
        Load_Data <= ext;
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit in the execute/memory boundary of the RISC-V core. It consumes the effective address produced by the ALU (ADD of rs1 and the immediate), aligns store data to byte lanes and drives a single-outstanding request/ready data-memory port. It then extracts and sign- or zero-extends load data for writeback. The core controller holds the pipeline while Busy is high.

## Interface
- DATAWIDTH, 32, data and address width; byte-lane logic is fixed at 4 lanes.
- CLK  in  1  core clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- Start  in  1  one-cycle request from the controller; sampled only in IDLE.
- Is_Store  in  1  1 = store, 0 = load; captured with Start.
- Funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- Alu_Result  in  DATAWIDTH  effective byte address from the ALU.
- Store_Data  in  DATAWIDTH  rs2 value; captured with Start.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  one-cycle completion pulse.
- Misaligned  out  1  valid with Done; 1 = access rejected for alignment.
- Load_Data  out  DATAWIDTH  extended load result; holds until the next load completes.
- Mem_Req  out  1  memory request, held until accepted.
- Mem_We  out  1  1 = write.
- Mem_Addr  out  DATAWIDTH  word address, {Alu_Result[31:2], 2'b00}.
- Mem_Be  out  4  byte enables.
- Mem_Wdata  out  DATAWIDTH  lane-replicated store data.
- Mem_Ready  in  1  memory accepts the request (and returns Rdata for loads) this cycle.
- Mem_Rdata  in  DATAWIDTH  read word; valid when Mem_Req and Mem_Ready are both high.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE with Start=1:
  - Capture Is_Store, Funct3, Alu_Result and Store_Data.
  - If the access is illegal or misaligned, go to DONE. Otherwise go to REQ.
- REQ:
  - Drive Mem_Req=1 with stable Mem_We, Mem_Addr, Mem_Be and Mem_Wdata.
  - When Mem_Ready=1, register the load result if the access is a load, then go to DONE.
  - With Mem_Ready=0, stay in REQ indefinitely.
- DONE: Done=1 for exactly one cycle, then return to IDLE.
- Start outside IDLE is ignored; no queuing.
- Byte enables and store data:
  - B: Mem_Be = 4'b0001 << addr[1:0]; Mem_Wdata = {4{Store_Data[7:0]}}.
  - H: Mem_Be = addr[1] ? 4'b1100 : 4'b0011; Mem_Wdata = {2{Store_Data[15:0]}}.
  - W: Mem_Be = 4'b1111; Mem_Wdata = Store_Data.
- Loads: shift lane = Mem_Rdata >> (8*addr[1:0]). B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through.
- Misalignment: H with addr[0]=1, or W with addr[1:0]!=0.
- Illegal Funct3 (011, 110, 111, or a store with Funct3[2]=1): no memory access, Done pulse with Misaligned=0, Load_Data unchanged.
- Misaligned: no memory access, Done pulse with Misaligned=1, Load_Data unchanged.

## Timing
- Reset values: every output is 0 (Busy, Done, Misaligned, Load_Data, Mem_Req, Mem_We, Mem_Addr, Mem_Be, Mem_Wdata); FSM is in IDLE.
- Start at edge N (legal access):
  - Mem_Req is high in cycle N+1.
  - If Mem_Ready is high in N+1, Done is high in N+2.
  - Each additional wait cycle adds one cycle.
- Illegal or misaligned access: Done is high in cycle N+1; Mem_Req never asserts.
- Busy is high in cycles N+1 through the Done cycle inclusive.
- Load_Data updates on the edge that leaves REQ, so it is valid in the Done cycle.
- Mem_Req deasserts in the Done cycle, so back-to-back requests are separated by at least one idle Mem_Req cycle.
- RESET mid-transaction:
  - FSM returns to IDLE on that edge and Mem_Req drops.
  - Any Mem_Ready or Mem_Rdata in that cycle is ignored, and no Done is produced.
- RESET and Start in the same cycle: RESET wins.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are rejected as described above.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misaligned is tied to 0.
  - H ignores addr[0] and W ignores addr[1:0] (forced natural alignment).
  - The access proceeds normally through REQ.

## Test plan
- LW at 0x100, Mem_Ready high immediately, Mem_Rdata=0xDEADBEEF:
  - Mem_Addr=0x100, Mem_Be=1111, Mem_Req in N+1.
  - Done in N+2 with Load_Data=0xDEADBEEF.
- LB at 0x103, Mem_Rdata=0x80123456 -> Load_Data=0xFFFFFF80. LBU at the same address -> Load_Data=0x00000080.
- SH at 0x202, Store_Data=0x0000ABCD, Mem_Ready held low 3 cycles:
  - Mem_Req stays high for 4 cycles with Mem_We=1, Mem_Be=1100, Mem_Wdata=0xABCDABCD.
  - Done in N+5.
- LW at 0x101:
  - With the macro: Done and Misaligned=1 in N+1, no Mem_Req.
  - Without the macro: Mem_Addr=0x100, Mem_Be=1111, Misaligned=0.
- Start during Busy is ignored (exactly one Done). RESET asserted in REQ clears all outputs to 0 with no Done. Store with Funct3=100 gives Done, no Mem_Req.
